// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin two-master arbiter onto one picorv32-style memory port,
// with a per-transaction timeout that forces completion with zero read data.
module mem_arbiter #(
  parameter int TIMEOUT  = 16,
  parameter bit M0_FIRST = 1'b1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        m0_valid,
  input  logic        m0_instr,
  input  logic [3:0]  m0_wstrb,
  input  logic [31:0] m0_wdata,
  input  logic [31:0] m0_addr,
  output logic        m0_ready,
  output logic [31:0] m0_rdata,
  input  logic        m1_valid,
  input  logic        m1_instr,
  input  logic [3:0]  m1_wstrb,
  input  logic [31:0] m1_wdata,
  input  logic [31:0] m1_addr,
  output logic        m1_ready,
  output logic [31:0] m1_rdata,
  output logic        s_valid,
  output logic        s_instr,
  output logic [3:0]  s_wstrb,
  output logic [31:0] s_wdata,
  output logic [31:0] s_addr,
  input  logic        s_ready,
  input  logic [31:0] s_rdata,
  output logic        timeout_err
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        gnt_q, gnt_d;
  logic        s_valid_q, s_valid_d, s_instr_q, s_instr_d;
  logic [3:0]  s_wstrb_q, s_wstrb_d;
  logic [31:0] s_wdata_q, s_wdata_d, s_addr_q, s_addr_d;
  logic        m0_ready_q, m0_ready_d, m1_ready_q, m1_ready_d, terr_q, terr_d;
  logic [31:0] m0_rdata_q, m0_rdata_d, m1_rdata_q, m1_rdata_d;
  logic        win, fin;
  logic [31:0] res;
  // gnt_q holds the last granted requester (1 = m1); a tie goes to the other one
  assign win = (m0_valid && m1_valid) ? ~gnt_q : m1_valid;
  assign fin = s_ready || (cnt_q == 8'(TIMEOUT - 1));
  assign res = s_ready ? s_rdata : 32'h0;
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    gnt_d      = gnt_q;
    s_valid_d  = 1'b0;
    s_instr_d  = s_instr_q;
    s_wstrb_d  = s_wstrb_q;
    s_wdata_d  = s_wdata_q;
    s_addr_d   = s_addr_q;
    m0_ready_d = 1'b0;
    m1_ready_d = 1'b0;
    terr_d     = 1'b0;
    m0_rdata_d = m0_rdata_q;
    m1_rdata_d = m1_rdata_q;
    unique case (state_q)
      IDLE: if (m0_valid || m1_valid) begin
        state_d   = BUSY;
        gnt_d     = win;
        cnt_d     = 8'd0;
        s_valid_d = 1'b1;
        s_instr_d = win ? m1_instr : m0_instr;
        s_wstrb_d = win ? m1_wstrb : m0_wstrb;
        s_wdata_d = win ? m1_wdata : m0_wdata;
        s_addr_d  = win ? m1_addr : m0_addr;
      end
      BUSY: begin
        cnt_d     = cnt_q + 8'd1;
        s_valid_d = !fin;
        if (fin) begin
          state_d    = DONE;
          m0_ready_d = !gnt_q;
          m1_ready_d = gnt_q;
          terr_d     = !s_ready;
          m0_rdata_d = gnt_q ? m0_rdata_q : res;
          m1_rdata_d = gnt_q ? res : m1_rdata_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      cnt_q      <= 8'd0;
      gnt_q      <= M0_FIRST;
      s_valid_q  <= 1'b0;
      s_instr_q  <= 1'b0;
      s_wstrb_q  <= 4'd0;
      s_wdata_q  <= 32'd0;
      s_addr_q   <= 32'd0;
      m0_ready_q <= 1'b0;
      m1_ready_q <= 1'b0;
      terr_q     <= 1'b0;
      m0_rdata_q <= 32'd0;
      m1_rdata_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      gnt_q      <= gnt_d;
      s_valid_q  <= s_valid_d;
      s_instr_q  <= s_instr_d;
      s_wstrb_q  <= s_wstrb_d;
      s_wdata_q  <= s_wdata_d;
      s_addr_q   <= s_addr_d;
      m0_ready_q <= m0_ready_d;
      m1_ready_q <= m1_ready_d;
      terr_q     <= terr_d;
      m0_rdata_q <= m0_rdata_d;
      m1_rdata_q <= m1_rdata_d;
    end
  end
  assign s_valid     = s_valid_q;
  assign s_instr     = s_instr_q;
  assign s_wstrb     = s_wstrb_q;
  assign s_wdata     = s_wdata_q;
  assign s_addr      = s_addr_q;
  assign m0_ready    = m0_ready_q;
  assign m1_ready    = m1_ready_q;
  assign m0_rdata    = m0_rdata_q;
  assign m1_rdata    = m1_rdata_q;
  assign timeout_err = terr_q;
endmodule
